// File: rtl/period_timer_pkg.sv
// Shared types and constants for the period timer: FSM state encoding,
// active-low seven-segment patterns and the duration clamp helper.
package period_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    // Active-low {dp,g,f,e,d,c,b,a}; all ones turns every segment off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit patterns, entry [d] holds the segments for digit d.
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h90,  // 9
        8'h80,  // 8
        8'hF8,  // 7
        8'h82,  // 6
        8'h92,  // 5
        8'h99,  // 4
        8'hB0,  // 3
        8'hA4,  // 2
        8'hF9,  // 1
        8'hC0   // 0
    };

    // A request of zero selects the default; oversize requests saturate.
    function automatic int unsigned clamp_seconds(input int unsigned req,
                                                  input int unsigned max_s,
                                                  input int unsigned def_s);
        if (req == 0) begin
            return def_s;
        end
        if (req > max_s) begin
            return max_s;
        end
        return req;
    endfunction

endpackage

// File: rtl/period_timer_seg7_digit_decoder.sv
// Registered BCD digit to active-low seven-segment decoder with blanking.
// Non-decimal codes are shown blank.
module seg7_digit_decoder
    import period_timer_pkg::*;
(
    input  logic       Clk100M,
    input  logic       Reset,
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);

    // Segment register, blank out of reset.
    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            seg <= SEG_BLANK;
        end else if (blank || (digit > 4'd9)) begin
            seg <= SEG_BLANK;
        end else begin
            seg <= SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/period_timer.sv
// Programmable countdown period timer with pause/abort, completion pulse,
// per-second tick and a two-digit seven-segment readout of seconds left.
// Optional warning blink is enabled by defining PERIOD_TIMER_WARN_EN.
module period_timer
    import period_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
    parameter int unsigned SEC_W           = 7,
    parameter int unsigned MAX_SECONDS     = 99,
    parameter int unsigned DEFAULT_SECONDS = 5
`ifdef PERIOD_TIMER_WARN_EN
    ,
    parameter int unsigned WARN_SECONDS    = 3
`endif
) (
    input  logic             Clk100M,
    input  logic             Reset,
    input  logic             startSig,
    input  logic [SEC_W-1:0] durationSec,
    input  logic             pauseSig,
    input  logic             abortSig,
    output logic             busy,
    output logic             levelComplete,
    output logic             tickSec,
    output logic [SEC_W-1:0] remainingSec,
    output logic [7:0]       postSeg0,
    output logic [7:0]       postSeg1,
    output logic [7:0]       postSeg2,
    output logic [7:0]       postSeg3
`ifdef PERIOD_TIMER_WARN_EN
    ,
    output logic             periodWarn
`endif
);

    localparam int unsigned      PRE_W    = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_HZ - 1);
`ifdef PERIOD_TIMER_WARN_EN
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_FREQ_HZ / 2);
`endif

    state_t             state;
    state_t             state_nxt;
    logic [PRE_W-1:0]   prescaler;
    logic               terminal;
    logic [SEC_W-1:0]   duration_d;
    logic [3:0]         tens;
    logic [3:0]         ones;
    logic [SEC_W-1:0]   tens_x10;
    logic               blink;
    logic               blank_tens;
    logic               blank_ones;

    assign terminal   = (prescaler == PRE_LAST);
    assign duration_d = SEC_W'(clamp_seconds(32'(durationSec), MAX_SECONDS, DEFAULT_SECONDS));
    assign postSeg2   = SEG_BLANK;
    assign postSeg3   = SEG_BLANK;

    // State register.
    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: abort beats pause, pause beats the terminal tick.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (startSig && !abortSig) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abortSig) begin
                    state_nxt = IDLE;
                end else if (pauseSig) begin
                    state_nxt = PAUSED;
                end else if (terminal && (remainingSec <= SEC_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            PAUSED: begin
                if (abortSig) begin
                    state_nxt = IDLE;
                end else if (!pauseSig) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy          = (state == RUN) || (state == PAUSED);
        levelComplete = (state == DONE);
    end

    // Prescaler, remaining seconds and the tick pulse.
    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            prescaler    <= '0;
            remainingSec <= '0;
            tickSec      <= 1'b0;
        end else begin
            tickSec <= 1'b0;
            case (state)
                IDLE: begin
                    prescaler    <= '0;
                    remainingSec <= (startSig && !abortSig) ? duration_d : '0;
                end
                RUN: begin
                    if (abortSig) begin
                        prescaler    <= '0;
                        remainingSec <= '0;
                    end else if (!pauseSig) begin
                        if (terminal) begin
                            prescaler    <= '0;
                            remainingSec <= (remainingSec != '0) ? remainingSec - SEC_W'(1) : '0;
                            tickSec      <= 1'b1;
                        end else begin
                            prescaler <= prescaler + PRE_W'(1);
                        end
                    end
                end
                PAUSED: begin
                    if (abortSig) begin
                        prescaler    <= '0;
                        remainingSec <= '0;
                    end
                end
                default: begin
                    prescaler    <= '0;
                    remainingSec <= '0;
                end
            endcase
        end
    end

    // Warning flag and blink gate for the last seconds of a period.
`ifdef PERIOD_TIMER_WARN_EN
    always_comb begin
        periodWarn = busy && (remainingSec <= SEC_W'(WARN_SECONDS));
        blink      = periodWarn && (state == RUN) && (prescaler >= PRE_HALF);
    end
`else
    assign blink = 1'b0;
`endif

    // Split remaining seconds into tens/units; ascending compare leaves the largest match.
    always_comb begin
        tens     = 4'd0;
        tens_x10 = '0;
        for (int unsigned t = 1; t <= 9; t++) begin
            if (remainingSec >= SEC_W'(10 * t)) begin
                tens     = 4'(t);
                tens_x10 = SEC_W'(10 * t);
            end
        end
        ones       = 4'(remainingSec - tens_x10);
        blank_ones = (state == IDLE) || blink;
        blank_tens = (state == IDLE) || (tens == 4'd0) || blink;
    end

    seg7_digit_decoder u_digit0 (
        .Clk100M (Clk100M),
        .Reset   (Reset),
        .digit   (ones),
        .blank   (blank_ones),
        .seg     (postSeg0)
    );

    seg7_digit_decoder u_digit1 (
        .Clk100M (Clk100M),
        .Reset   (Reset),
        .digit   (tens),
        .blank   (blank_tens),
        .seg     (postSeg1)
    );

endmodule

// File: tb/tb_period_timer.sv
// Randomised scoreboard bench for period_timer with a 10-cycle second.
module tb_period_timer;

    localparam int CF = 10;
    localparam int SW = 7;

    logic          Clk100M = 1'b0;
    logic          Reset = 1'b1;
    logic          startSig = 1'b0;
    logic          pauseSig = 1'b0;
    logic          abortSig = 1'b0;
    logic [SW-1:0] durationSec = '0;
    logic          busy;
    logic          levelComplete;
    logic          tickSec;
    logic [SW-1:0] remainingSec;
    logic [7:0]    postSeg0;
    logic [7:0]    postSeg1;
    logic [7:0]    postSeg2;
    logic [7:0]    postSeg3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int e;
        int rem;
    } tick_t;

    tick_t tick_q[$];
    int    done_q[$];

    period_timer #(
        .CLK_FREQ_HZ     (CF),
        .SEC_W           (SW),
        .MAX_SECONDS     (99),
        .DEFAULT_SECONDS (5)
    ) dut (
        .Clk100M       (Clk100M),
        .Reset         (Reset),
        .startSig      (startSig),
        .durationSec   (durationSec),
        .pauseSig      (pauseSig),
        .abortSig      (abortSig),
        .busy          (busy),
        .levelComplete (levelComplete),
        .tickSec       (tickSec),
        .remainingSec  (remainingSec),
        .postSeg0      (postSeg0),
        .postSeg1      (postSeg1),
        .postSeg2      (postSeg2),
        .postSeg3      (postSeg3)
    );

    always #5 Clk100M = ~Clk100M;

    always @(posedge Clk100M) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int seg_of(input int d);
        case (d)
            0: return 'hC0;
            1: return 'hF9;
            2: return 'hA4;
            3: return 'hB0;
            4: return 'h99;
            5: return 'h92;
            6: return 'h82;
            7: return 'hF8;
            8: return 'h80;
            9: return 'h90;
            default: return 'hFF;
        endcase
    endfunction

    function automatic int tens_seg(input int v);
        return (v / 10 == 0) ? 'hFF : seg_of(v / 10);
    endfunction

    // Monitor: pops expected events whenever the DUT pulses tickSec or levelComplete.
    int    sp_pend = 0;
    int    sp_rem  = 0;
    tick_t mt;
    int    md;
    always @(negedge Clk100M) begin
        if (!Reset) begin
            if (sp_pend != 0) begin
                chk("seg0_after_tick", int'(postSeg0), seg_of(sp_rem % 10));
                chk("seg1_after_tick", int'(postSeg1), tens_seg(sp_rem));
                sp_pend = 0;
            end
            if (tickSec) begin
                if (tick_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tick_unexpected: tickSec=1 at cycle %0d, none expected", cyc);
                end else begin
                    mt = tick_q.pop_front();
                    chk("tick_cycle", cyc, mt.e);
                    chk("tick_rem", int'(remainingSec), mt.rem);
                    sp_pend = 1;
                    sp_rem  = mt.rem;
                end
            end
            if (levelComplete) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: levelComplete=1 at cycle %0d, none expected", cyc);
                end else begin
                    md = done_q.pop_front();
                    chk("done_cycle", cyc, md);
                    chk("done_busy", int'(busy), 0);
                end
            end
        end else begin
            sp_pend = 0;
        end
    end

    // One timer period: offsets are edges after the accepted start edge, 0 = unused.
    task automatic run_case(input int req, input int poff, input int plen,
                            input int aoff, input int soff);
        int n, d, lost, a, dn, ende, cnt;
        int te[$];
        d    = (req == 0) ? 5 : ((req > 99) ? 99 : req);
        n    = cyc + 1;
        lost = (plen > 0) ? plen + 1 : 0;
        a    = (aoff > 0) ? n + aoff : 32'h7fff_ffff;
        dn   = n + d * CF + lost;
        for (int k = 1; k <= d; k++) begin
            if (n + k * CF + lost < a) begin
                te.push_back(n + k * CF + lost);
                tick_q.push_back(tick_t'{n + k * CF + lost, d - k});
            end
        end
        if (dn < a) done_q.push_back(dn);
        ende = (dn < a) ? dn : a;

        startSig    = 1'b1;
        durationSec = SW'(req);
        @(negedge Clk100M);
        startSig = 1'b0;

        for (int c = n; c <= ende + 3; c++) begin
            cnt = 0;
            foreach (te[i]) if (te[i] <= c) cnt++;
            chk("rem", int'(remainingSec), (c >= a) ? 0 : d - cnt);
            chk("busy", int'(busy), (c < ende) ? 1 : 0);
            if (c == n + 1) begin
                chk("seg0_start", int'(postSeg0), seg_of(d % 10));
                chk("seg1_start", int'(postSeg1), tens_seg(d));
            end
            pauseSig = (plen > 0) && (c + 1 >= n + poff) && (c + 1 < n + poff + plen);
            abortSig = (c + 1 == a);
            startSig = (soff > 0) && (c + 1 == n + soff);
            @(negedge Clk100M);
        end
        pauseSig = 1'b0;
        abortSig = 1'b0;
        startSig = 1'b0;
        chk("ticks_left", tick_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        chk("seg0_idle", int'(postSeg0), 'hFF);
        chk("seg1_idle", int'(postSeg1), 'hFF);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(levelComplete), 0);
        chk({tag, "_tick"}, int'(tickSec), 0);
        chk({tag, "_rem"}, int'(remainingSec), 0);
        chk({tag, "_seg0"}, int'(postSeg0), 'hFF);
        chk({tag, "_seg1"}, int'(postSeg1), 'hFF);
        chk({tag, "_seg2"}, int'(postSeg2), 'hFF);
        chk({tag, "_seg3"}, int'(postSeg3), 'hFF);
    endtask

    initial begin
        int n, req, d, poff, plen, aoff, soff, lost;
        repeat (3) @(negedge Clk100M);
        check_reset_outputs("reset");
        Reset = 1'b0;
        @(negedge Clk100M);

        run_case(3, 0, 0, 0, 0);
        run_case(0, 0, 0, 0, 0);
        run_case(120, 0, 0, 0, 0);
        run_case(2, 4, 9, 0, 0);
        run_case(3, 0, 0, 15, 0);
        run_case(4, 0, 0, 0, 5);
        run_case(1, 0, 0, 0, 11);

        // Start together with abort while idle must not launch a period.
        startSig    = 1'b1;
        abortSig    = 1'b1;
        durationSec = 7'd7;
        @(negedge Clk100M);
        startSig = 1'b0;
        abortSig = 1'b0;
        repeat (3) begin
            chk("startabort_busy", int'(busy), 0);
            chk("startabort_rem", int'(remainingSec), 0);
            @(negedge Clk100M);
        end

        // Asynchronous reset in the middle of a run with three seconds left.
        n           = cyc + 1;
        startSig    = 1'b1;
        durationSec = 7'd5;
        @(negedge Clk100M);
        startSig = 1'b0;
        tick_q.push_back(tick_t'{n + CF, 4});
        tick_q.push_back(tick_t'{n + 2 * CF, 3});
        repeat (2 * CF + 3) @(negedge Clk100M);
        chk("prereset_rem", int'(remainingSec), 3);
        chk("prereset_busy", int'(busy), 1);
        #2 Reset = 1'b1;
        tick_q.delete();
        done_q.delete();
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge Clk100M);
        Reset = 1'b0;
        repeat (25) @(negedge Clk100M);
        chk("postreset_busy", int'(busy), 0);
        chk("postreset_rem", int'(remainingSec), 0);
        chk("postreset_seg0", int'(postSeg0), 'hFF);

        for (int i = 0; i < 24; i++) begin
            int r;
            r    = int'($urandom_range(0, 9));
            req  = (r == 0) ? int'($urandom_range(100, 127)) :
                   ((r == 1) ? 0 : int'($urandom_range(1, 9)));
            d    = (req == 0) ? 5 : ((req > 99) ? 99 : req);
            poff = 0;
            plen = 0;
            aoff = 0;
            soff = 0;
            if ($urandom_range(0, 2) == 0) begin
                poff = int'($urandom_range(1, CF - 1));
                plen = int'($urandom_range(1, 15));
            end
            lost = (plen > 0) ? plen + 1 : 0;
            if ($urandom_range(0, 3) == 0) aoff = int'($urandom_range(1, d * CF + lost));
            if ($urandom_range(0, 2) == 0) begin
                if (aoff == 0) soff = int'($urandom_range(1, d * CF + lost + 1));
                else if (aoff > 1) soff = int'($urandom_range(1, aoff - 1));
            end
            run_case(req, poff, plen, aoff, soff);
            repeat ($urandom_range(0, 2)) @(negedge Clk100M);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
